// File: rtl/m_trap_sequencer.sv
// m_trap_sequencer
//   Issuing side of the machine-mode CSR trap interface. It picks one event per
//   idle cycle: an execute/memory exception, a fetch/decode exception, mret or a
//   pending machine interrupt. It then writes mepc/mcause/mtval/mstatus through
//   a single CSR write port, one register per enabled cycle, and finishes with
//   a one-cycle fetch redirect.
//
// Ports
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_clk_en                  sequencer advances only while high
//   i_exception_*_f_d_ff      fetch/decode exception code and PC
//   i_exception_*_e_m_ff      execute/memory exception code, PC, data address
//   i_mret_e                  mret in execute
//   i_irq_ext/sw/timer        level interrupt lines
//   i_irq_pc                  PC of the next instruction to commit (interrupt mepc)
//   i_mstatus/mie/mtvec/mepc  current CSR values
//   o_csr_write_*, o_csr_data single CSR write port
//   o_flush, o_stall          pipeline control
//   o_redirect_valid/pc       one-cycle fetch redirect
module m_trap_sequencer #(
    parameter logic [1:0] XLEN = 2'd2,      // 2-bit width code; 2'd2 selects 64-bit
    parameter logic [3:0] NO_E = 4'hF,      // exception code meaning "no exception"
    localparam int W = 1 << (int'(XLEN) + 4)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clk_en,
    input  logic [3:0]    i_exception_code_f_d_ff,
    input  logic [31:0]   i_exception_pc_f_d_ff,
    input  logic [3:0]    i_exception_code_e_m_ff,
    input  logic [31:0]   i_exception_pc_e_m_ff,
    input  logic [31:0]   i_exception_addr_e_m_ff,
    input  logic          i_mret_e,
    input  logic          i_irq_ext,
    input  logic          i_irq_sw,
    input  logic          i_irq_timer,
    input  logic [31:0]   i_irq_pc,
    input  logic [W-1:0]  i_mstatus,
    input  logic [W-1:0]  i_mie,
    input  logic [W-1:0]  i_mtvec,
    input  logic [W-1:0]  i_mepc,
    output logic [11:0]   o_csr_write_addr,
    output logic [W-1:0]  o_csr_data,
    output logic          o_csr_write_enable,
    output logic          o_flush,
    output logic          o_stall,
    output logic          o_redirect_valid,
    output logic [W-1:0]  o_redirect_pc
);

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_W_MEPC    = 3'd1,
        ST_W_MCAUSE  = 3'd2,
        ST_W_MTVAL   = 3'd3,
        ST_W_MSTATUS = 3'd4,
        ST_REDIRECT  = 3'd5
    } state_t;

    // Zero-extend a 32-bit PC/address to the data width.
    function automatic logic [W-1:0] zext32(input logic [31:0] v);
        return W'(v);
    endfunction

    // Interrupt cause: id with the interrupt flag in the top bit.
    function automatic logic [W-1:0] irq_cause(input logic [3:0] id);
        return W'(id) | (W'(1'b1) << (W - 1));
    endfunction

    // mstatus on trap entry: MPIE <= MIE, MIE <= 0, MPP <= M.
    function automatic logic [W-1:0] trap_status(input logic [W-1:0] ms);
        logic [W-1:0] r;
        r        = ms;
        r[7]     = ms[3];
        r[3]     = 1'b0;
        r[12:11] = 2'b11;
        return r;
    endfunction

    // mstatus on mret: MIE <= MPIE, MPIE <= 1, MPP <= M.
    function automatic logic [W-1:0] mret_status(input logic [W-1:0] ms);
        logic [W-1:0] r;
        r        = ms;
        r[3]     = ms[7];
        r[7]     = 1'b1;
        r[12:11] = 2'b11;
        return r;
    endfunction

    // Trap vector: vectored mode only offsets interrupts; reserved modes use base.
    function automatic logic [W-1:0] trap_target(input logic [W-1:0] tvec,
                                                 input logic [W-1:0] cause,
                                                 input logic         is_irq);
        logic [W-1:0] base;
        base = tvec & ~W'(2'b11);
        if ((tvec[1:0] == 2'b01) && is_irq) begin
            return base + (W'(cause[3:0]) << 2);
        end else begin
            return base;
        end
    endfunction

    state_t         state_r, state_nx_s;
    logic [W-1:0]   cause_r, cause_nx_s;
    logic [W-1:0]   epc_r, epc_nx_s;
    logic [W-1:0]   tval_r, tval_nx_s;
    logic           irq_r, irq_nx_s;
    logic           mret_r, mret_nx_s;
    logic           accept_s;

    logic           em_valid_s, fd_valid_s;
    logic [W-1:0]   line_vec_s, irq_eff_s;
    logic [3:0]     irq_id_s;

    logic [11:0]    csr_addr_r, csr_addr_nx_s;
    logic [W-1:0]   csr_data_r, csr_data_nx_s;
    logic           csr_we_r, csr_we_nx_s;
    logic           flush_r, stall_r, redir_valid_r;
    logic [W-1:0]   redir_pc_r, redir_pc_nx_s;

    assign em_valid_s = (i_exception_code_e_m_ff != NO_E);
    assign fd_valid_s = (i_exception_code_f_d_ff != NO_E);

    // Place the interrupt lines at their mie bit positions and qualify them.
    always_comb begin
        line_vec_s     = '0;
        line_vec_s[11] = i_irq_ext;
        line_vec_s[3]  = i_irq_sw;
        line_vec_s[7]  = i_irq_timer;
        irq_eff_s      = i_mie & line_vec_s & {W{i_mstatus[3]}};
    end

    // Fixed interrupt priority: external, software, timer.
    always_comb begin
        if (irq_eff_s[11]) begin
            irq_id_s = 4'd11;
        end else if (irq_eff_s[3]) begin
            irq_id_s = 4'd3;
        end else if (irq_eff_s[7]) begin
            irq_id_s = 4'd7;
        end else begin
            irq_id_s = 4'd0;
        end
    end

    // Next state and captured trap information; arbitration happens only in IDLE.
    always_comb begin
        state_nx_s = state_r;
        cause_nx_s = cause_r;
        epc_nx_s   = epc_r;
        tval_nx_s  = tval_r;
        irq_nx_s   = irq_r;
        mret_nx_s  = mret_r;
        accept_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (em_valid_s) begin
                    // Older instruction wins; a coincident f_d exception or mret is dropped.
                    accept_s   = 1'b1;
                    state_nx_s = ST_W_MEPC;
                    cause_nx_s = W'(i_exception_code_e_m_ff);
                    epc_nx_s   = zext32(i_exception_pc_e_m_ff);
                    tval_nx_s  = zext32(i_exception_addr_e_m_ff);
                    irq_nx_s   = 1'b0;
                    mret_nx_s  = 1'b0;
                end else if (fd_valid_s) begin
                    accept_s   = 1'b1;
                    state_nx_s = ST_W_MEPC;
                    cause_nx_s = W'(i_exception_code_f_d_ff);
                    epc_nx_s   = zext32(i_exception_pc_f_d_ff);
                    tval_nx_s  = zext32(i_exception_pc_f_d_ff);
                    irq_nx_s   = 1'b0;
                    mret_nx_s  = 1'b0;
                end else if (i_mret_e) begin
                    accept_s   = 1'b1;
                    state_nx_s = ST_W_MSTATUS;
                    irq_nx_s   = 1'b0;
                    mret_nx_s  = 1'b1;
                end else if (|irq_eff_s) begin
                    accept_s   = 1'b1;
                    state_nx_s = ST_W_MEPC;
                    cause_nx_s = irq_cause(irq_id_s);
                    epc_nx_s   = zext32(i_irq_pc);
                    tval_nx_s  = '0;
                    irq_nx_s   = 1'b1;
                    mret_nx_s  = 1'b0;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_W_MEPC:    state_nx_s = ST_W_MCAUSE;
            ST_W_MCAUSE:  state_nx_s = ST_W_MTVAL;
            ST_W_MTVAL:   state_nx_s = ST_W_MSTATUS;
            ST_W_MSTATUS: state_nx_s = ST_REDIRECT;
            ST_REDIRECT:  state_nx_s = ST_IDLE;
            default:      state_nx_s = ST_IDLE;
        endcase
    end

    // Output values for the state being entered, so the output registers line up with it.
    always_comb begin
        csr_addr_nx_s = 12'h000;
        csr_data_nx_s = '0;
        csr_we_nx_s   = 1'b0;
        redir_pc_nx_s = '0;
        case (state_nx_s)
            ST_W_MEPC: begin
                csr_addr_nx_s = CSR_MEPC;
                csr_data_nx_s = epc_nx_s;
                csr_we_nx_s   = 1'b1;
            end
            ST_W_MCAUSE: begin
                csr_addr_nx_s = CSR_MCAUSE;
                csr_data_nx_s = cause_nx_s;
                csr_we_nx_s   = 1'b1;
            end
            ST_W_MTVAL: begin
                csr_addr_nx_s = CSR_MTVAL;
                csr_data_nx_s = tval_nx_s;
                csr_we_nx_s   = 1'b1;
            end
            ST_W_MSTATUS: begin
                csr_addr_nx_s = CSR_MSTATUS;
                csr_data_nx_s = mret_nx_s ? mret_status(i_mstatus) : trap_status(i_mstatus);
                csr_we_nx_s   = 1'b1;
            end
            ST_REDIRECT: begin
                if (mret_nx_s) begin
                    redir_pc_nx_s = i_mepc & ~W'(2'b11);
                end else begin
                    redir_pc_nx_s = trap_target(i_mtvec, cause_nx_s, irq_nx_s);
                end
            end
            default: begin
                csr_we_nx_s = 1'b0;
            end
        endcase
    end

    // State, captured trap data and registered outputs; everything holds while disabled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r       <= ST_IDLE;
            cause_r       <= '0;
            epc_r         <= '0;
            tval_r        <= '0;
            irq_r         <= 1'b0;
            mret_r        <= 1'b0;
            csr_addr_r    <= 12'h000;
            csr_data_r    <= '0;
            csr_we_r      <= 1'b0;
            flush_r       <= 1'b0;
            stall_r       <= 1'b0;
            redir_valid_r <= 1'b0;
            redir_pc_r    <= '0;
        end else if (i_clk_en) begin
            state_r       <= state_nx_s;
            cause_r       <= cause_nx_s;
            epc_r         <= epc_nx_s;
            tval_r        <= tval_nx_s;
            irq_r         <= irq_nx_s;
            mret_r        <= mret_nx_s;
            csr_addr_r    <= csr_addr_nx_s;
            csr_data_r    <= csr_data_nx_s;
            csr_we_r      <= csr_we_nx_s;
            flush_r       <= accept_s;
            stall_r       <= (state_nx_s != ST_IDLE);
            redir_valid_r <= (state_nx_s == ST_REDIRECT);
            redir_pc_r    <= redir_pc_nx_s;
        end
    end

    // The strobe is masked while disabled so a frozen write cycle is not committed twice.
    assign o_csr_write_enable = csr_we_r & i_clk_en;
    assign o_csr_write_addr   = csr_addr_r;
    assign o_csr_data         = csr_data_r;
    assign o_flush            = flush_r;
    assign o_stall            = stall_r;
    assign o_redirect_valid   = redir_valid_r;
    assign o_redirect_pc      = redir_pc_r;

endmodule

// File: tb/tb_m_trap_sequencer.sv
module tb_m_trap_sequencer;

    localparam logic [1:0] XLEN = 2'd2;
    localparam int         W    = 64;
    localparam logic [3:0] NO_E = 4'hF;

    logic          i_clk;
    logic          i_rst_n;
    logic          i_clk_en;
    logic [3:0]    i_exception_code_f_d_ff;
    logic [31:0]   i_exception_pc_f_d_ff;
    logic [3:0]    i_exception_code_e_m_ff;
    logic [31:0]   i_exception_pc_e_m_ff;
    logic [31:0]   i_exception_addr_e_m_ff;
    logic          i_mret_e;
    logic          i_irq_ext, i_irq_sw, i_irq_timer;
    logic [31:0]   i_irq_pc;
    logic [W-1:0]  i_mstatus, i_mie, i_mtvec, i_mepc;
    logic [11:0]   o_csr_write_addr;
    logic [W-1:0]  o_csr_data;
    logic          o_csr_write_enable, o_flush, o_stall, o_redirect_valid;
    logic [W-1:0]  o_redirect_pc;

    m_trap_sequencer #(.XLEN(XLEN), .NO_E(NO_E)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clk_en(i_clk_en),
        .i_exception_code_f_d_ff(i_exception_code_f_d_ff),
        .i_exception_pc_f_d_ff(i_exception_pc_f_d_ff),
        .i_exception_code_e_m_ff(i_exception_code_e_m_ff),
        .i_exception_pc_e_m_ff(i_exception_pc_e_m_ff),
        .i_exception_addr_e_m_ff(i_exception_addr_e_m_ff),
        .i_mret_e(i_mret_e), .i_irq_ext(i_irq_ext), .i_irq_sw(i_irq_sw),
        .i_irq_timer(i_irq_timer), .i_irq_pc(i_irq_pc),
        .i_mstatus(i_mstatus), .i_mie(i_mie), .i_mtvec(i_mtvec), .i_mepc(i_mepc),
        .o_csr_write_addr(o_csr_write_addr), .o_csr_data(o_csr_data),
        .o_csr_write_enable(o_csr_write_enable), .o_flush(o_flush), .o_stall(o_stall),
        .o_redirect_valid(o_redirect_valid), .o_redirect_pc(o_redirect_pc)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [11:0]  addr;
        logic [W-1:0] data;
    } wr_t;

    wr_t           exp_wr_q[$];
    logic [W-1:0]  exp_pc_q[$];
    wr_t           mon_w;
    logic [W-1:0]  mon_pc;
    int            total = 0;
    int            bad = 0;
    int            en_edges = 0;
    int            acc = 0;
    int            lat = 0;
    int            mon_pos = 0;
    bit            active = 1'b0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Enabled-edge counter used to measure latency in enabled cycles.
    always @(posedge i_clk) begin
        if (i_rst_n && i_clk_en) en_edges <= en_edges + 1;
    end

    // Monitor: pops the scoreboard on CSR writes and redirects, checks pipeline control timing.
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (o_csr_write_enable) begin
                if (exp_wr_q.size() == 0) begin
                    check("write_unexpected", W'(o_csr_write_addr), W'(12'h000));
                end else begin
                    mon_w = exp_wr_q.pop_front();
                    check("csr_addr", W'(o_csr_write_addr), W'(mon_w.addr));
                    check("csr_data", o_csr_data, mon_w.data);
                end
            end
            if (o_redirect_valid && i_clk_en) begin
                if (exp_pc_q.size() == 0) begin
                    check("redirect_unexpected", o_redirect_pc, '0);
                end else begin
                    mon_pc = exp_pc_q.pop_front();
                    check("redirect_pc", o_redirect_pc, mon_pc);
                end
            end
            if (active) begin
                mon_pos = en_edges - acc + 1;
                if (mon_pos <= lat) begin
                    check("flush_timing", W'(o_flush), W'(mon_pos == 1));
                    check("stall_timing", W'(o_stall), W'(1'b1));
                    check("redirect_timing", W'(o_redirect_valid), W'(mon_pos == lat));
                end else begin
                    check("stall_release", W'(o_stall), W'(1'b0));
                    active = 1'b0;
                end
            end else begin
                check("idle_stall", W'(o_stall), W'(1'b0));
                check("idle_flush", W'(o_flush), W'(1'b0));
                check("idle_redirect", W'(o_redirect_valid), W'(1'b0));
            end
        end
    end

    task automatic clear_events();
        i_exception_code_f_d_ff = NO_E;
        i_exception_code_e_m_ff = NO_E;
        i_mret_e    = 1'b0;
        i_irq_ext   = 1'b0;
        i_irq_sw    = 1'b0;
        i_irq_timer = 1'b0;
    endtask

    task automatic push_wr(input logic [11:0] a, input logic [W-1:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_wr_q.push_back(w);
    endtask

    // Reference model: derive the expected CSR writes, redirect and latency from the
    // currently driven inputs, then present them for one enabled (acceptance) edge.
    task automatic go(input bit rand_en, input bit do_finish);
        logic [W-1:0] cause, epc, tval, ms_new, target, topbit;
        bit           trap, is_irq, is_mret;
        int           n;
        trap = 1'b0; is_irq = 1'b0; is_mret = 1'b0;
        cause = '0; epc = '0; tval = '0;
        topbit = '0;
        topbit[W-1] = 1'b1;
        if (i_exception_code_e_m_ff != NO_E) begin
            trap = 1'b1; cause = W'(i_exception_code_e_m_ff);
            epc = W'(i_exception_pc_e_m_ff); tval = W'(i_exception_addr_e_m_ff);
        end else if (i_exception_code_f_d_ff != NO_E) begin
            trap = 1'b1; cause = W'(i_exception_code_f_d_ff);
            epc = W'(i_exception_pc_f_d_ff); tval = W'(i_exception_pc_f_d_ff);
        end else if (i_mret_e) begin
            is_mret = 1'b1;
        end else if (i_mstatus[3] && ((i_mie[11] && i_irq_ext) || (i_mie[3] && i_irq_sw) || (i_mie[7] && i_irq_timer))) begin
            trap = 1'b1; is_irq = 1'b1; epc = W'(i_irq_pc); tval = '0;
            if (i_mie[11] && i_irq_ext) cause = topbit + 11;
            else if (i_mie[3] && i_irq_sw) cause = topbit + 3;
            else cause = topbit + 7;
        end
        if (trap) begin
            ms_new = i_mstatus;
            ms_new[7] = i_mstatus[3];
            ms_new[3] = 1'b0;
            ms_new[12:11] = 2'b11;
            target = i_mtvec - (i_mtvec % 4);
            if ((i_mtvec % 4) == 1 && is_irq) target = target + 4 * (cause % 16);
            push_wr(12'h341, epc);
            push_wr(12'h342, cause);
            push_wr(12'h343, tval);
            push_wr(12'h300, ms_new);
            exp_pc_q.push_back(target);
        end else if (is_mret) begin
            ms_new = i_mstatus;
            ms_new[3] = i_mstatus[7];
            ms_new[7] = 1'b1;
            ms_new[12:11] = 2'b11;
            push_wr(12'h300, ms_new);
            exp_pc_q.push_back(i_mepc - (i_mepc % 4));
        end
        i_clk_en = 1'b1;
        @(posedge i_clk);
        #1;
        clear_events();
        if (trap || is_mret) begin
            acc = en_edges;
            lat = trap ? 5 : 2;
            active = 1'b1;
        end
        if (do_finish) begin
            n = 0;
            while (active && n < 300) begin
                i_clk_en = rand_en ? ($urandom_range(0, 3) != 0) : 1'b1;
                @(posedge i_clk);
                #1;
                n = n + 1;
            end
            i_clk_en = 1'b1;
            if (active) begin
                check("sequence_timeout", W'(n), W'(0));
                active = 1'b0;
            end
            repeat (2) @(posedge i_clk);
            #1;
            check("wr_queue_drained", W'(exp_wr_q.size()), W'(0));
            check("pc_queue_drained", W'(exp_pc_q.size()), W'(0));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_addr"}, W'(o_csr_write_addr), W'(12'h000));
        check({tag, "_data"}, o_csr_data, '0);
        check({tag, "_we"}, W'(o_csr_write_enable), W'(1'b0));
        check({tag, "_flush"}, W'(o_flush), W'(1'b0));
        check({tag, "_stall"}, W'(o_stall), W'(1'b0));
        check({tag, "_rvalid"}, W'(o_redirect_valid), W'(1'b0));
        check({tag, "_rpc"}, o_redirect_pc, '0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        i_rst_n = 1'b0;
        i_clk_en = 1'b1;
        clear_events();
        i_exception_pc_f_d_ff = 32'h0; i_exception_pc_e_m_ff = 32'h0;
        i_exception_addr_e_m_ff = 32'h0; i_irq_pc = 32'h0;
        i_mstatus = '0; i_mie = '0; i_mtvec = '0; i_mepc = '0;
        repeat (3) @(posedge i_clk);
        #1;
        check_all_zero("reset");
        i_rst_n = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;

        // e_m exception into direct-mode vector
        i_exception_code_e_m_ff = 4'h5; i_exception_pc_e_m_ff = 32'h100;
        i_exception_addr_e_m_ff = 32'h2003; i_mtvec = 64'h800; i_mstatus = 64'h8;
        go(1'b0, 1'b1);

        // both exception stages valid: e_m wins
        i_exception_code_f_d_ff = 4'h2; i_exception_pc_f_d_ff = 32'h200;
        i_exception_code_e_m_ff = 4'h4; i_exception_pc_e_m_ff = 32'h1FC;
        i_exception_addr_e_m_ff = 32'h44;
        go(1'b0, 1'b1);

        // external interrupt into vectored mode
        i_mtvec = 64'h801; i_mstatus = 64'h8; i_mie = 64'h800;
        i_irq_ext = 1'b1; i_irq_pc = 32'h40;
        go(1'b0, 1'b1);

        // timer masked by MIE=0, then enabled
        i_mstatus = 64'h0; i_mie = 64'h80; i_irq_timer = 1'b1;
        go(1'b0, 1'b1);
        i_mstatus = 64'h8; i_mie = 64'h80; i_irq_timer = 1'b1; i_mtvec = 64'h801;
        go(1'b0, 1'b1);

        // mret
        i_mepc = 64'h123; i_mstatus = 64'h80; i_mret_e = 1'b1;
        go(1'b0, 1'b1);

        // exception coincident with mret
        i_mret_e = 1'b1; i_exception_code_f_d_ff = 4'h1; i_exception_pc_f_d_ff = 32'h300;
        go(1'b0, 1'b1);

        // randomized traffic with random clock-enable gaps
        for (int k = 0; k < 40; k++) begin
            i_exception_code_e_m_ff = ($urandom_range(0, 3) == 0) ? 4'($urandom) : NO_E;
            i_exception_code_f_d_ff = ($urandom_range(0, 3) == 0) ? 4'($urandom) : NO_E;
            i_exception_pc_e_m_ff = $urandom; i_exception_addr_e_m_ff = $urandom;
            i_exception_pc_f_d_ff = $urandom; i_irq_pc = $urandom;
            i_mret_e = ($urandom_range(0, 3) == 0);
            i_irq_ext = 1'($urandom); i_irq_sw = 1'($urandom); i_irq_timer = 1'($urandom);
            i_mstatus = {$urandom, $urandom}; i_mie = {$urandom, $urandom};
            i_mtvec = {$urandom, $urandom}; i_mepc = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 0) i_mtvec[1:0] = 2'b01;
            go(1'b1, 1'b1);
        end

        // freeze mid-trap, then reset mid-trap
        i_mstatus = 64'h8; i_mtvec = 64'h800;
        i_exception_code_e_m_ff = 4'h5; i_exception_pc_e_m_ff = 32'h100;
        i_exception_addr_e_m_ff = 32'h2003;
        go(1'b0, 1'b0);
        @(posedge i_clk);
        #1;
        i_clk_en = 1'b0;
        for (int d = 0; d < 3; d++) begin
            @(negedge i_clk);
            check("frozen_addr", W'(o_csr_write_addr), W'(12'h342));
            check("frozen_data", o_csr_data, 64'h5);
            check("frozen_we", W'(o_csr_write_enable), W'(1'b0));
            check("frozen_stall", W'(o_stall), W'(1'b1));
            check("frozen_flush", W'(o_flush), W'(1'b0));
            @(posedge i_clk);
            #1;
        end
        i_clk_en = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        active = 1'b0;
        exp_wr_q.delete();
        exp_pc_q.delete();
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        repeat (6) @(posedge i_clk);
        #1;

        // sequencer accepts again from IDLE after reset
        i_mepc = 64'h456; i_mstatus = 64'h0; i_mret_e = 1'b1;
        go(1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/m_trap_sequencer.md
Name: m_trap_sequencer

Overview:
- Issuing side of the machine-mode CSR file's trap interface.
- Arbitrates pipeline exceptions, pending machine interrupts and mret.
- Drives a single CSR write port one register per cycle (mepc, mcause, mtval, mstatus).
- Flushes and stalls the pipeline, then issues a one-cycle fetch redirect to the trap vector or to mepc.

Parameters:
XLEN, `XLEN_64b, 2-bit width code from Constants.vh; data width W = 1<<(XLEN+4)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous, active-low reset
i_clk_en  in  1  FSM advances only when high
i_exception_code_f_d_ff  in  4  fetch/decode exception code; `NO_E = none
i_exception_pc_f_d_ff  in  32  PC of faulting fetch/decode instruction
i_exception_code_e_m_ff  in  4  execute/memory exception code; `NO_E = none
i_exception_pc_e_m_ff  in  32  PC of faulting execute/memory instruction
i_exception_addr_e_m_ff  in  32  faulting data address
i_mret_e  in  1  mret in execute
i_irq_ext, i_irq_sw, i_irq_timer  in  1 each  level interrupt lines
i_irq_pc  in  32  PC of next instruction to commit (mepc for interrupts)
i_mstatus, i_mie, i_mtvec, i_mepc  in  W  current CSR values
o_csr_write_addr  out  12  CSR address being written
o_csr_data  out  W  write data
o_csr_write_enable  out  1  write strobe
o_flush  out  1  kill all in-flight instructions
o_stall  out  1  hold fetch while sequencing
o_redirect_valid  out  1  one-cycle pulse
o_redirect_pc  out  W  new fetch PC

Behaviour:
- Reset (async, i_rst_n=0): state IDLE; all outputs 0; captured cause/pc/tval registers 0. Reset asserted mid-sequence aborts with no further CSR writes.
- Effective interrupt: mstatus.MIE(bit3) & mie[k] & line. Bits/causes: ext = 11, sw = 3, timer = 7.
- IDLE arbitration, evaluated only when i_clk_en=1. Priority:
  1. e_m exception (older instruction)
  2. f_d exception
  3. mret
  4. ext interrupt
  5. sw interrupt
  6. timer interrupt
- Capture on a trap:
  - cause = code zero-extended; for interrupts cause = id with bit W-1 set.
  - epc = pc, or i_irq_pc for interrupts.
  - tval = e_m addr for e_m exceptions, f_d pc for f_d exceptions, 0 for interrupts.
- Trap sequence: IDLE -> W_MEPC -> W_MCAUSE -> W_MTVAL -> W_MSTATUS -> REDIRECT -> IDLE.
  - One CSR write per enabled cycle.
  - Addresses `mepc, `mcause, `mtval, `mstatus.
- Trap mstatus write: MPIE <= MIE; MIE <= 0; MPP <= 2'b11; all other bits unchanged from i_mstatus sampled in W_MSTATUS.
- mret sequence: IDLE -> W_MSTATUS -> REDIRECT -> IDLE.
  - mstatus write: MIE <= MPIE; MPIE <= 1; MPP <= 2'b11.
  - Redirect target = i_mepc with bits[1:0] cleared.
- Trap redirect target from i_mtvec:
  - mode bits[1:0]=00: base (mtvec & ~3).
  - mode 01 and interrupt: base + 4*cause[3:0].
  - mode 01 and exception, or modes 10/11: base.
- Arithmetic is W-bit and wraps modulo 2^W. 32-bit PCs are zero-extended to W.
- Timing from acceptance edge:
  - o_flush is high for exactly the cycle after acceptance.
  - o_stall is high from the cycle after acceptance through REDIRECT inclusive.
  - o_redirect_valid is high only in REDIRECT.
  - Trap latency: acceptance to redirect = 5 enabled cycles. mret = 2.
- i_clk_en=0: state, outputs and captured values frozen. o_csr_write_enable forced 0 while disabled.
- Events arriving outside IDLE are ignored; flush guarantees re-execution or replay.
- An exception coincident with mret: the exception wins and mret is dropped.
- Both exception codes valid together: e_m taken; f_d discarded.
- Interrupt lines deasserting after acceptance do not abort the sequence.

Test Plan:
- e_m code 4'h5, pc 0x100, addr 0x2003, mtvec 0x800, mstatus MIE=1 -> writes mepc=0x100, mcause=5, mtval=0x2003, mstatus MIE=0/MPIE=1/MPP=11; redirect 0x800 on 5th cycle after acceptance.
- f_d code 4'h2 and e_m code 4'h4 in same cycle -> mcause=4; f_d ignored; single flush pulse.
- mtvec 0x801, MIE=1, mie[11]=1, i_irq_ext=1, i_irq_pc 0x40 -> mcause has bit W-1 set plus 11, mepc=0x40, mtval=0; redirect 0x82C.
- i_irq_timer with mstatus MIE=0 -> stays IDLE, no writes. Set MIE=1, mie[7]=1 -> trap taken.
- mret with mepc 0x123, MPIE=1 -> mstatus MIE=1, MPIE=1; redirect 0x120 two cycles after acceptance.
- Drop i_clk_en for 3 cycles mid-trap, then deassert i_rst_n mid-trap -> outputs frozen while disabled; after reset all outputs 0 immediately, state IDLE.
